jump_resolve: RTL and testbench
===============================

JUMP_RESOLVE -- requirements
Module: jump_resolve

Interface
REQ-001 Parameter XLEN, default 32: width of PC and writeback data.
REQ-002 Parameter RW, default 5: register-index width.
REQ-003 Clock: one clock `clk`; all state updates on the rising edge of `clk`.
REQ-004 Reset: `rst` is synchronous and active-high.
REQ-005 Ports, in order:
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous active-high reset.
- `fu_finish`, input, 1: one-cycle pulse; jump-FU result valid.
- `fu_cmp_res`, input, 1: branch comparison result.
- `fu_uncond`, input, 1: instruction is JAL/JALR.
- `fu_pred_taken`, input, 1: fetch-stage prediction for this instruction.
- `fu_pc_jump`, input, XLEN: target address.
- `fu_pc_wb`, input, XLEN: PC+4.
- `fu_rd`, input, RW: destination register.
- `busy`, output, 1: unit holding a result.
- `redirect_valid`, output, 1: fetch redirect request.
- `redirect_pc`, output, XLEN: redirect address.
- `redirect_ready`, input, 1: fetch accepts redirect.
- `flush`, output, 1: one-cycle pulse to squash younger instructions.
- `wb_req`, output, 1: writeback bus request.
- `wb_rd`, output, RW: writeback destination.
- `wb_data`, output, XLEN: link value.
- `wb_grant`, input, 1: writeback bus grant.
- `overrun`, output, 1: sticky protocol-error flag.

Function
REQ-006 States: IDLE, RESOLVE, ISSUE; encoding in the shared package.
REQ-007 IDLE with `fu_finish`=1: capture all fu_* inputs into registers; next state RESOLVE.
REQ-008 RESOLVE, one cycle:
- taken = uncond | cmp_res.
- need_redir = (taken != pred_taken).
- need_wb = uncond & (rd != 0).
REQ-009 RESOLVE with need_redir=0 and need_wb=0: next state IDLE.
REQ-010 RESOLVE otherwise: next state ISSUE; `redirect_valid` <= need_redir and `wb_req` <= need_wb, both registered.
REQ-011 `redirect_pc` = taken ? captured pc_jump : captured pc_wb.
REQ-012 `wb_rd` = captured rd; `wb_data` = captured pc_wb.
REQ-013 Both outputs are stable while their valid/req is high.
REQ-014 `redirect_valid` holds until sampled with `redirect_ready`=1; then it clears.
REQ-015 `wb_req` holds until sampled with `wb_grant`=1; then it clears.
REQ-016 The two handshakes are independent and may complete in the same or different cycles.
REQ-017 `flush` is high for exactly the cycle after the redirect handshake edge.
REQ-018 ISSUE to IDLE on the edge where the last outstanding handshake completes.
REQ-019 `busy` = (state != IDLE), combinational.
REQ-020 `fu_finish`=1 while `busy`=1 is ignored (no capture) and sets `overrun`; this includes the final ISSUE cycle.
REQ-021 `fu_finish` in IDLE is accepted immediately; no idle bubble is required after a return to IDLE.
REQ-022 `redirect_ready`/`wb_grant` arriving while the matching request is low has no effect.

Reset
REQ-023 `rst` at a clock edge forces state IDLE and clears `redirect_valid`, `wb_req`, `flush` and `overrun`, overriding every other input.
REQ-024 Captured data registers and `redirect_pc`/`wb_rd`/`wb_data` reset to 0.
REQ-025 `rst` mid-ISSUE abandons outstanding handshakes; no `flush` pulse follows.

Structure
REQ-026 Shared package jr_pkg holds the state typedef, XLEN/RW defaults and the zero-register constant.
REQ-027 One sub-module, jr_hs_slot, holds a single valid/ready request bit with set/clear/rst; it is instantiated twice (redirect, writeback).

Verification
REQ-028 Scenario A:
- Stimulus: BEQ, cmp_res=1, pred=0, pc_jump=0x100, pc_wb=0x24, redirect_ready=1.
- Required: redirect_valid 2 cycles after finish with redirect_pc=0x100; flush 1 cycle; wb_req never high.
REQ-029 Scenario B:
- Stimulus: BNE, cmp_res=0, pred=1, pc_wb=0x48.
- Required: redirect_pc=0x48, flush pulses once.
REQ-030 Scenario C:
- Stimulus: JAL, rd=1, pred=1, pc_jump=0x200, pc_wb=0x14, wb_grant delayed 3 cycles.
- Required: no redirect; wb_req held 3 cycles with wb_rd=1, wb_data=0x14; busy drops the cycle after grant.
REQ-031 Scenario D:
- Stimulus: JALR, rd=0, pred=0, pc_jump=0x80; redirect_ready low for 2 cycles.
- Required: wb_req never high; redirect held until ready; then IDLE.
REQ-032 Scenario E:
- Stimulus: second fu_finish while ISSUE.
- Required: ignored, overrun=1 sticky until rst; captured values unchanged.
REQ-033 Scenario F:
- Stimulus: rst asserted mid-ISSUE.
- Required: next cycle all outputs 0, busy=0, no flush.

Source files
------------

// File: rtl/jr_pkg.sv
// Shared types and constants for the jump-resolution unit.
package jr_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RW_DEF   = 5;
  localparam int ZERO_REG = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_ISSUE   = 2'd2
  } jr_state_e;

endpackage

// File: rtl/jr_hs_slot.sv
// One outstanding valid/ready request bit; set when the request is issued,
// cleared when the consumer samples it with ready high.
module jr_hs_slot (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic ready,
  output logic valid,
  output logic fire
);

  logic valid_r;

  assign valid = valid_r;
  assign fire  = valid_r & ready;

  // request bit: set has priority, a completed handshake clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (set) begin
      valid_r <= 1'b1;
    end else if (fire) begin
      valid_r <= 1'b0;
    end
  end

endmodule

// File: rtl/jump_resolve.sv
// Resolves a finished jump/branch: raises a fetch redirect on misprediction
// and a link writeback for JAL/JALR, then waits for both handshakes.
module jump_resolve
  import jr_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RW   = RW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fu_finish,
  input  logic            fu_cmp_res,
  input  logic            fu_uncond,
  input  logic            fu_pred_taken,
  input  logic [XLEN-1:0] fu_pc_jump,
  input  logic [XLEN-1:0] fu_pc_wb,
  input  logic [RW-1:0]   fu_rd,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            flush,
  output logic            wb_req,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  input  logic            wb_grant,
  output logic            overrun
);

  jr_state_e       state_r, state_s;
  logic            cmp_r, uncond_r, pred_r;
  logic [XLEN-1:0] pc_jump_r, pc_wb_r;
  logic [RW-1:0]   rd_r;
  logic            taken_s, need_redir_s, need_wb_s;
  logic            capture_s, resolve_s;
  logic            redir_fire_s, wb_fire_s;
  logic [XLEN-1:0] redirect_pc_r, wb_data_r;
  logic [RW-1:0]   wb_rd_r;
  logic            flush_r, overrun_r;

  assign taken_s      = uncond_r | cmp_r;
  assign need_redir_s = (taken_s != pred_r);
  assign need_wb_s    = uncond_r & (rd_r != RW'(ZERO_REG));
  assign busy         = (state_r != ST_IDLE);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state and capture/resolve strobes
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    resolve_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fu_finish) begin
          capture_s = 1'b1;
          state_s   = ST_RESOLVE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RESOLVE: begin
        resolve_s = 1'b1;
        if (need_redir_s | need_wb_s) begin
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // leave on the edge where the last outstanding handshake completes
        if ((!redirect_valid | redirect_ready) & (!wb_req | wb_grant)) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // capture of the finishing instruction; later finishes while busy are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_r     <= 1'b0;
      uncond_r  <= 1'b0;
      pred_r    <= 1'b0;
      pc_jump_r <= '0;
      pc_wb_r   <= '0;
      rd_r      <= '0;
    end else if (capture_s) begin
      cmp_r     <= fu_cmp_res;
      uncond_r  <= fu_uncond;
      pred_r    <= fu_pred_taken;
      pc_jump_r <= fu_pc_jump;
      pc_wb_r   <= fu_pc_wb;
      rd_r      <= fu_rd;
    end
  end

  // request payloads are fixed in RESOLVE and held stable through ISSUE
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc_r <= '0;
      wb_rd_r       <= '0;
      wb_data_r     <= '0;
    end else if (resolve_s) begin
      redirect_pc_r <= taken_s ? pc_jump_r : pc_wb_r;
      wb_rd_r       <= rd_r;
      wb_data_r     <= pc_wb_r;
    end
  end

  // flush follows the redirect handshake by one cycle; overrun is sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      flush_r   <= redir_fire_s;
      overrun_r <= overrun_r | (busy & fu_finish);
    end
  end

  jr_hs_slot u_redir_slot (
    .clk   (clk),
    .rst   (rst),
    .set   (resolve_s & need_redir_s),
    .ready (redirect_ready),
    .valid (redirect_valid),
    .fire  (redir_fire_s)
  );

  jr_hs_slot u_wb_slot (
    .clk   (clk),
    .rst   (rst),
    .set   (resolve_s & need_wb_s),
    .ready (wb_grant),
    .valid (wb_req),
    .fire  (wb_fire_s)
  );

  assign redirect_pc = redirect_pc_r;
  assign wb_rd       = wb_rd_r;
  assign wb_data     = wb_data_r;
  assign flush       = flush_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_jump_resolve.sv
// Directed plus randomized checks of jump_resolve against a transaction-level model.
module tb_jump_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        fu_finish, fu_cmp_res, fu_uncond, fu_pred_taken;
  logic [31:0] fu_pc_jump, fu_pc_wb;
  logic [4:0]  fu_rd;
  logic        busy, redirect_valid, redirect_ready, flush;
  logic [31:0] redirect_pc, wb_data;
  logic        wb_req, wb_grant, overrun;
  logic [4:0]  wb_rd;

  int n_vec = 0;
  int n_err = 0;
  bit ov_exp = 1'b0;

  always #5 clk = ~clk;

  jump_resolve #(.XLEN(32), .RW(5)) dut (
    .clk            (clk),
    .rst            (rst),
    .fu_finish      (fu_finish),
    .fu_cmp_res     (fu_cmp_res),
    .fu_uncond      (fu_uncond),
    .fu_pred_taken  (fu_pred_taken),
    .fu_pc_jump     (fu_pc_jump),
    .fu_pc_wb       (fu_pc_wb),
    .fu_rd          (fu_rd),
    .busy           (busy),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush          (flush),
    .wb_req         (wb_req),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_grant       (wb_grant),
    .overrun        (overrun)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble_fu();
    fu_cmp_res    = 1'($urandom);
    fu_uncond     = 1'($urandom);
    fu_pred_taken = 1'($urandom);
    fu_pc_jump    = $urandom;
    fu_pc_wb      = $urandom;
    fu_rd         = 5'($urandom);
  endtask

  // One instruction end to end. rdy_d/gnt_d: handshake cycle in ISSUE at which
  // ready/grant first go high; inj_k: ISSUE cycle with a stray finish;
  // rst_k: ISSUE cycle at which reset is applied (-1 disables).
  task automatic run_txn(input string nm, input bit cmp, input bit unc, input bit pred,
                         input logic [31:0] pcj, input logic [31:0] pcw, input logic [4:0] rd,
                         input int rdy_d, input int gnt_d, input int inj_k, input int rst_k);
    bit          taken, rv, wb, fl, rst_hit;
    logic [31:0] rpc;
    taken   = unc || cmp;
    rv      = (taken != pred);
    wb      = unc && (rd != 5'd0);
    rpc     = taken ? pcj : pcw;
    fl      = 1'b0;
    rst_hit = 1'b0;

    fu_finish = 1'b1; fu_cmp_res = cmp; fu_uncond = unc; fu_pred_taken = pred;
    fu_pc_jump = pcj; fu_pc_wb = pcw; fu_rd = rd;
    redirect_ready = 1'($urandom); wb_grant = 1'($urandom);
    step();
    fu_finish = 1'b0;
    scramble_fu();
    chk1({nm, ".resolve_busy"}, busy, 1'b1);
    chk1({nm, ".resolve_rv"}, redirect_valid, 1'b0);
    chk1({nm, ".resolve_wb"}, wb_req, 1'b0);
    step();

    for (int k = 0; k < 64 && (rv || wb); k++) begin
      redirect_ready = (k >= rdy_d);
      wb_grant       = (k >= gnt_d);
      chk1({nm, ".busy"}, busy, 1'b1);
      chk1({nm, ".redirect_valid"}, redirect_valid, rv);
      chk1({nm, ".wb_req"}, wb_req, wb);
      chk1({nm, ".flush"}, flush, fl);
      chk1({nm, ".overrun"}, overrun, ov_exp);
      if (rv) chkw({nm, ".redirect_pc"}, redirect_pc, rpc);
      if (wb) chkw({nm, ".wb_rd"}, 32'(wb_rd), 32'(rd));
      if (wb) chkw({nm, ".wb_data"}, wb_data, pcw);
      if (k == inj_k) begin
        scramble_fu();
        fu_finish = 1'b1;
      end
      if (k == rst_k) begin
        rst = 1'b1; redirect_ready = 1'b1; wb_grant = 1'b1;
      end
      step();
      fu_finish = 1'b0;
      if (k == inj_k) ov_exp = 1'b1;
      if (k == rst_k) begin
        rst = 1'b0; ov_exp = 1'b0; rv = 1'b0; wb = 1'b0; fl = 1'b0; rst_hit = 1'b1;
      end else begin
        fl = rv && redirect_ready;
        if (rv && redirect_ready) rv = 1'b0;
        if (wb && wb_grant) wb = 1'b0;
      end
    end
    chk1({nm, ".handshake_timeout"}, rv || wb, 1'b0);
    chk1({nm, ".done_busy"}, busy, 1'b0);
    chk1({nm, ".done_flush"}, flush, fl);
    chk1({nm, ".done_rv"}, redirect_valid, 1'b0);
    chk1({nm, ".done_wb"}, wb_req, 1'b0);
    chk1({nm, ".done_overrun"}, overrun, ov_exp);
    if (rst_hit) begin
      chkw({nm, ".rst_redirect_pc"}, redirect_pc, 32'h0);
      chkw({nm, ".rst_wb_rd"}, 32'(wb_rd), 32'h0);
      chkw({nm, ".rst_wb_data"}, wb_data, 32'h0);
    end
    redirect_ready = 1'b0;
    wb_grant       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fu_finish = 1'b0; redirect_ready = 1'b0; wb_grant = 1'b0;
    scramble_fu();
    @(negedge clk);
    step();
    rst = 1'b0;
    chk1("reset.busy", busy, 1'b0);
    chk1("reset.redirect_valid", redirect_valid, 1'b0);
    chk1("reset.wb_req", wb_req, 1'b0);
    chk1("reset.flush", flush, 1'b0);
    chk1("reset.overrun", overrun, 1'b0);
    chkw("reset.redirect_pc", redirect_pc, 32'h0);
    chkw("reset.wb_rd", 32'(wb_rd), 32'h0);
    chkw("reset.wb_data", wb_data, 32'h0);

    // A: mispredicted-not-taken BEQ, fetch ready at once
    run_txn("A", 1'b1, 1'b0, 1'b0, 32'h100, 32'h24, 5'd3, 0, 0, -1, -1);
    // B: mispredicted-taken BNE falls through to pc_wb
    run_txn("B", 1'b0, 1'b0, 1'b1, 32'h3c0, 32'h48, 5'd7, 0, 0, -1, -1);
    // C: correctly predicted JAL, link writeback with delayed grant
    run_txn("C", 1'b0, 1'b1, 1'b1, 32'h200, 32'h14, 5'd1, 0, 3, -1, -1);
    // D: JALR to x0 predicted not-taken, fetch stalls 2 cycles
    run_txn("D", 1'b0, 1'b1, 1'b0, 32'h80, 32'h30, 5'd0, 2, 0, -1, -1);
    // correctly predicted branch: no ISSUE at all
    run_txn("nop", 1'b1, 1'b0, 1'b1, 32'h44, 32'h10, 5'd5, 0, 0, -1, -1);
    // E: stray finish in ISSUE, mid-way and on the final cycle
    run_txn("E1", 1'b0, 1'b1, 1'b0, 32'h600, 32'h104, 5'd9, 3, 2, 1, -1);
    run_txn("E2", 1'b0, 1'b1, 1'b1, 32'h700, 32'h208, 5'd4, 0, 2, 2, -1);

    for (int i = 0; i < 40; i++) begin
      run_txn("rnd", 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
              5'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1, -1);
    end

    // F: reset mid-ISSUE while both handshakes are pending
    run_txn("F", 1'b0, 1'b1, 1'b0, 32'h900, 32'h50, 5'd2, 9, 9, 0, 1);
    step();
    chk1("F.no_late_flush", flush, 1'b0);
    chk1("F.idle_busy", busy, 1'b0);
    run_txn("post_F", 1'b1, 1'b0, 1'b0, 32'h1234, 32'h88, 5'd6, 1, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
